// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Purpose  : Top-level sequencer for the layered CNN datapath. Runs a
//            weight-load phase, then enables NUM_LAYERS chained layer blocks
//            from their ready/stall handshakes until the last layer finishes.
//            Supports continuous multi-frame operation, optional reload per
//            frame, abort, a run watchdog and a completed-frame counter.
//            All registers update on the falling clock edge so that outputs
//            are stable when the layers sample them on the rising edge.
// Ports    : clk, rst_n (async, active-low)
//            en          - run request (level); low pauses LOAD/RUN
//            continuous  - auto-start next frame after done while en is high
//            abort       - synchronous return to IDLE
//            ready/stall - per-layer output-valid / output-paused flags
//            load_weight - weight-load strobe
//            layer_en    - per-layer enables
//            busy        - high in LOAD or RUN
//            done        - one-cycle pulse per completed frame
//            error       - watchdog expired, sticky until IDLE
//            frame_count - completed frames since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int NUM_LAYERS        = 3,
    parameter int LOAD_CYCLES       = 906,
    parameter int TIMEOUT_CYCLES    = 0,
    parameter int RELOAD_EACH_FRAME = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] ready,
    input  logic [NUM_LAYERS-1:0] stall,
    output logic                  load_weight,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           frame_count
);

    localparam int c_last   = NUM_LAYERS - 1;
    localparam int c_load_w = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int c_run_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_load_w-1:0] c_load_last = c_load_w'(LOAD_CYCLES - 1);
    // Watchdog fires on the unpaused RUN edge that completes the last allowed cycle.
    localparam logic [c_run_w-1:0]  c_run_last  =
        (TIMEOUT_CYCLES > 0) ? c_run_w'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_load_w-1:0] r_load_cnt;
    logic [c_run_w-1:0]  r_run_cnt;

    // The last layer's stall flag has no consumer in this sequencer.
    logic w_unused_stall;
    assign w_unused_stall = stall[c_last];

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_run_cnt   <= '0;
            load_weight <= 1'b0;
            layer_en    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frame_count <= 16'd0;
        end else if (abort) begin
            // frame_count deliberately survives an abort.
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_run_cnt   <= '0;
            load_weight <= 1'b0;
            layer_en    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state     <= S_LOAD;
                        load_weight <= 1'b1;
                        busy        <= 1'b1;
                        r_load_cnt  <= '0;
                    end
                end

                S_LOAD: begin
                    if (en) begin
                        if (r_load_cnt == c_load_last) begin
                            r_state     <= S_RUN;
                            load_weight <= 1'b0;
                            layer_en    <= NUM_LAYERS'(1);
                            r_run_cnt   <= '0;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    // Completion outranks the watchdog and a pause.
                    if (ready[c_last]) begin
                        r_state     <= S_DONE;
                        layer_en    <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else if ((TIMEOUT_CYCLES > 0) && en && (r_run_cnt == c_run_last)) begin
                        r_state  <= S_ERR;
                        layer_en <= '0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end else if (en) begin
                        r_run_cnt   <= r_run_cnt + 1'b1;
                        layer_en[0] <= 1'b1;
                        // Middle layers: stall clears, ready sets, else hold.
                        for (int k = 1; k < c_last; k++) begin
                            if (stall[k-1]) begin
                                layer_en[k] <= 1'b0;
                            end else if (ready[k-1]) begin
                                layer_en[k] <= 1'b1;
                            end
                        end
                        layer_en[c_last] <= ready[c_last-1] & stall[c_last-1];
                    end
                end

                S_DONE: begin
                    if (continuous && en) begin
                        busy <= 1'b1;
                        if (RELOAD_EACH_FRAME != 0) begin
                            r_state     <= S_LOAD;
                            load_weight <= 1'b1;
                            r_load_cnt  <= '0;
                        end else begin
                            r_state   <= S_RUN;
                            layer_en  <= NUM_LAYERS'(1);
                            r_run_cnt <= '0;
                        end
                    end else if (!en) begin
                        r_state <= S_IDLE;
                    end
                end

                S_ERR: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        error   <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    load_weight <= 1'b0;
                    layer_en    <= '0;
                    busy        <= 1'b0;
                    error       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Parametrised top-level sequencer for the layered CNN datapath. It drives a weight-load phase, then enables NUM_LAYERS pipelined layer blocks from their ready/stall handshakes until the last layer reports completion. It adds continuous multi-frame operation, optional weight reload, abort, a run watchdog, and a frame counter. It sits in the top module between the external `en` request and the layer instances, and replaces the hard-coded three-layer enable logic.

## Interface
- NUM_LAYERS, 3, number of chained layers (2..8)
- LOAD_CYCLES, 906, clock cycles `load_weight` is held high per load phase (>=1)
- TIMEOUT_CYCLES, 0, maximum RUN cycles per frame before error; 0 disables the watchdog
- RELOAD_EACH_FRAME, 0, 1 = repeat the load phase before every frame in continuous mode
- clk  in  1  clock; all registers update on the falling edge so outputs are stable at the layers' rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run request (level)
- continuous  in  1  1 = start the next frame automatically after done while `en` is high
- abort  in  1  synchronous return to IDLE
- ready  in  NUM_LAYERS  per-layer "output valid" flags
- stall  in  NUM_LAYERS  per-layer "output paused" flags
- load_weight  out  1  weight-load strobe to all layers
- layer_en  out  NUM_LAYERS  per-layer enables
- busy  out  1  high in LOAD or RUN
- done  out  1  one-cycle pulse per completed frame
- error  out  1  watchdog expired; sticky until IDLE
- frame_count  out  16  completed frames since reset, wraps at 65535 -> 0

## Operation
- States: IDLE, LOAD, RUN, DONE, ERR. All outputs are registered.
- Reset values: state IDLE; all outputs 0; internal counters 0.
- IDLE
  - `en`=1: go to LOAD, set `load_weight`=1, clear the load counter.
- LOAD
  - Load counter increments each edge.
  - After LOAD_CYCLES cycles of `load_weight`=1: go to RUN, `load_weight`=0, `layer_en[0]`=1, clear the run counter.
- RUN (edge updates)
  - `layer_en[0]` held at 1.
  - Middle layers, for k = 1..NUM_LAYERS-2: `stall[k-1]` clears `layer_en[k]`; otherwise `ready[k-1]` sets it; otherwise it holds. Stall has priority over ready.
  - Last layer: `layer_en[NUM_LAYERS-1]` <= `ready[NUM_LAYERS-2] & stall[NUM_LAYERS-2]`.
  - `ready[NUM_LAYERS-1]`=1: all `layer_en` go to 0, `done`=1, `frame_count`+1, go to DONE.
  - Watchdog (TIMEOUT_CYCLES>0): the run counter reaches TIMEOUT_CYCLES -> all `layer_en`=0, `error`=1, go to ERR.
- DONE
  - `done` is high only on the entry cycle.
  - `continuous`=1 and `en`=1: go to LOAD if RELOAD_EACH_FRAME, else go to RUN directly with `layer_en[0]`=1 and the run counter cleared.
  - `en`=0: go to IDLE.
  - Otherwise hold.
- ERR: `error` held at 1; `en`=0 -> IDLE with `error` cleared.
- Pause: `en`=0 in LOAD or RUN freezes state, counters and all outputs. `en`=1 resumes from the same point.
- `abort`=1 in any state: next edge goes to IDLE with all outputs 0 except `frame_count`, which is preserved.
- Priority on the same edge: abort > completion (`ready[NUM_LAYERS-1]`) > watchdog > pause > normal enable rules.

## Timing
- `en` sampled high at edge n in IDLE: `load_weight`=1 after edge n. `layer_en[0]`=1 after edge n+LOAD_CYCLES.
- Handshake response latency: exactly one edge from `ready`/`stall` sampled to `layer_en` updated.
- Completion: `ready[NUM_LAYERS-1]` sampled at edge m -> after edge m, `layer_en`=0 and `done`=1. `done` returns to 0 after edge m+1.
- Continuous, no reload: `layer_en[0]` back to 1 after edge m+1, i.e. one idle cycle between frames.
- The watchdog counts only unpaused RUN cycles.
- `rst_n` low mid-frame: all outputs go to 0 immediately, with no clock required.

## Test plan
- NUM_LAYERS=3, LOAD_CYCLES=4. Raise `en`.
  - Required: `load_weight` high for exactly 4 cycles, then `layer_en`=3'b001.
  - Then drive `ready[0]`=1 -> `layer_en[1]`=1 next edge.
  - Then drive `ready[1]`&`stall[1]`=1 -> `layer_en[2]`=1.
  - Then drive `ready[2]`=1 -> `layer_en`=0, one `done` pulse, `frame_count`=1.
- Stall priority: in RUN drive `ready[0]`=1 and `stall[0]`=1 together -> `layer_en[1]`=0 next edge. Release `stall[0]` -> `layer_en[1]`=1.
- Continuous mode, RELOAD_EACH_FRAME=0: run 3 frames -> `load_weight` asserted only once, 3 `done` pulses each followed one cycle later by `layer_en[0]`=1, `frame_count`=3. Repeat with RELOAD_EACH_FRAME=1 -> 3 load phases of 4 cycles each.
- Pause and abort:
  - Drop `en` at load cycle 2 for 5 cycles -> `load_weight` stays 1 and the load still totals 4 cycles.
  - `abort` in RUN -> IDLE, outputs 0, `frame_count` unchanged.
- Watchdog: TIMEOUT_CYCLES=10, never assert `ready[2]` -> after 10 RUN cycles `error`=1 and `layer_en`=0. `en`=0 -> `error`=0. Asserting `ready[2]` on cycle 10 instead -> `done` pulse, no error.
- Reset: assert `rst_n`=0 mid-RUN between clock edges -> all outputs 0 immediately. Release `rst_n` with `en`=1 -> a new load phase starts.
